// File: rtl/div_share_sched.sv
// div_share_sched: round-robin sharing of one repeated-subtraction
// divide datapath between two requesters.
//
// Ports:
//   CLK, reset        clock, synchronous active-high reset
//   req0/req1         client requests, held with operands until done
//   a0,b0 / a1,b1     client dividend / divisor (unsigned)
//   gnt[1:0]          one-hot grant, LOAD through DONE
//   done[1:0]         one-cycle completion pulse to served client
//   busy              high whenever not IDLE
//   err               divide-by-zero or iteration timeout, valid with done
//   quot, rem         result registers, held until the next done
//   dp_a, dp_b        latched operands driven to the datapath
//   dp_s, dp_we       datapath mux select (0 load, 1 subtract), temp write
//   dp_x, dp_temp     datapath compare (temp < dp_b) and temp value
module div_share_sched #(
  parameter int WIDTH    = 32,
  parameter int MAX_ITER = 65535
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic             err,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic             dp_s,
  output logic             dp_we,
  input  logic             dp_x,
  input  logic [WIDTH-1:0] dp_temp
);

  localparam int CW = $clog2(MAX_ITER + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_ITER);

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_SUB, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Client 1 wins when it is the only requester, or when both
  // request and the pointer currently favours it.
  logic             sel1;
  logic [WIDTH-1:0] a_sel, b_sel;

  assign sel1  = req1 & (~req0 | ptr_q);
  assign a_sel = sel1 ? a1 : a0;
  assign b_sel = sel1 ? b1 : b0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    err_d   = err_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    dp_s    = 1'b0;
    dp_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          gnt_d = sel1 ? 2'b10 : 2'b01;
          ptr_d = ~sel1;
          a_d   = a_sel;
          b_d   = b_sel;
          cnt_d = '0;
          if (b_sel == '0) begin
            // Zero divisor never reaches the datapath.
            err_d   = 1'b1;
            quot_d  = '1;
            rem_d   = a_sel;
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        dp_we   = 1'b1;
        state_d = S_SUB;
      end
      S_SUB: begin
        dp_s = 1'b1;
        if (dp_x) begin
          quot_d  = WIDTH'(cnt_q);
          rem_d   = dp_temp;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == MAXC) begin
          quot_d  = WIDTH'(cnt_q);
          rem_d   = dp_temp;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          dp_we = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 2'b00;
      err_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = (state_q == S_DONE) ? gnt_q : 2'b00;
  assign busy = (state_q != S_IDLE);
  assign err  = err_q;
  assign quot = quot_q;
  assign rem  = rem_q;
  assign dp_a = a_q;
  assign dp_b = b_q;

endmodule

// File: tb/tb_div_share_sched.sv
// tb_div_share_sched: directed bench for div_share_sched with a
// behavioural model of the shared divide datapath.
module tb_div_share_sched;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   gnt, done;
  logic         busy, err;
  logic [W-1:0] quot, rem, dp_a, dp_b;
  logic         dp_s, dp_we, dp_x;
  logic [W-1:0] dp_temp = '0;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always #5 CLK = ~CLK;

  always_ff @(posedge CLK)
    if (dp_we) dp_temp <= dp_s ? dp_temp - dp_b : dp_a;

  assign dp_x = dp_temp < dp_b;

  div_share_sched #(
    .WIDTH(W),
    .MAX_ITER(8)
  ) dut (
    .CLK(CLK), .reset(reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .done(done), .busy(busy), .err(err),
    .quot(quot), .rem(rem),
    .dp_a(dp_a), .dp_b(dp_b),
    .dp_s(dp_s), .dp_we(dp_we),
    .dp_x(dp_x), .dp_temp(dp_temp)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
  endtask

  // Steps cycles until a done pulse (bounded), checking the grant
  // while busy and tallying datapath activity.
  task automatic serve(input string tag,
                       input logic [1:0] exp,
                       input int exp_cyc,
                       input bit scramble,
                       output int we_n,
                       output int sub_n);
    int bad;
    int got_cyc;
    bad = 0; got_cyc = -1; we_n = 0; sub_n = 0;
    for (int k = 1; k <= 40 && got_cyc < 0; k++) begin
      @(negedge CLK);
      cyc++;
      if (busy && gnt !== exp) bad++;
      if (dp_we) we_n++;
      if (dp_s) sub_n++;
      if (scramble && k == 1) begin
        req0 = 1'b0; req1 = 1'b0;
        a0 = $urandom; b0 = $urandom;
        a1 = $urandom; b1 = $urandom;
      end
      if (done != 2'b00) begin
        got_cyc = cyc;
        chk({tag, "_done_mask"}, done, exp);
      end
    end
    chk({tag, "_gnt_held"}, bad, 0);
    chk({tag, "_done_cycle"}, got_cyc, exp_cyc);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_quot"}, quot, 0);
    chk({tag, "_rem"}, rem, 0);
    chk({tag, "_dp_a"}, dp_a, 0);
    chk({tag, "_dp_b"}, dp_b, 0);
    chk({tag, "_dp_s_we"}, {dp_s, dp_we}, 0);
  endtask

  initial begin
    int we_n, sub_n;

    do_reset();
    chk_reset_vals("rst");

    // 17 / 5 on client 0
    req0 = 1'b1; a0 = 17; b0 = 5; cyc = 0;
    serve("t1", 2'b01, 6, 1'b0, we_n, sub_n);
    chk("t1_quot", quot, 3);
    chk("t1_rem", rem, 2);
    chk("t1_err", err, 0);
    chk("t1_dp_a", dp_a, 17);
    chk("t1_dp_b", dp_b, 5);
    chk("t1_sub_cycles", sub_n, 4);
    req0 = 1'b0;
    @(negedge CLK);
    chk("t1_pulse_one_cycle", done, 0);
    chk("t1_idle", {busy, gnt}, 0);

    // both request: client 0 first, client 1 right after
    do_reset();
    req0 = 1'b1; a0 = 10; b0 = 3;
    req1 = 1'b1; a1 = 9;  b1 = 9;
    cyc = 0;
    serve("t2a", 2'b01, 6, 1'b0, we_n, sub_n);
    chk("t2a_quot", quot, 3);
    chk("t2a_rem", rem, 1);
    req0 = 1'b0;
    serve("t2b", 2'b10, 11, 1'b0, we_n, sub_n);
    chk("t2b_quot", quot, 1);
    chk("t2b_rem", rem, 0);
    chk("t2b_err", err, 0);
    req1 = 1'b0;
    @(negedge CLK);

    // dividend smaller than divisor
    do_reset();
    req1 = 1'b1; a1 = 4; b1 = 7; cyc = 0;
    serve("t3", 2'b10, 3, 1'b0, we_n, sub_n);
    chk("t3_quot", quot, 0);
    chk("t3_rem", rem, 4);
    chk("t3_err", err, 0);
    chk("t3_sub_cycles", sub_n, 1);
    req1 = 1'b0;
    @(negedge CLK);

    // divide by zero
    do_reset();
    req0 = 1'b1; a0 = 55; b0 = 0; cyc = 0;
    serve("t4", 2'b01, 1, 1'b0, we_n, sub_n);
    chk("t4_err", err, 1);
    chk("t4_quot", quot, 32'hFFFF_FFFF);
    chk("t4_rem", rem, 55);
    chk("t4_no_we", we_n, 0);
    req0 = 1'b0;
    @(negedge CLK);

    // timeout at MAX_ITER=8; req and operands drop mid-operation
    do_reset();
    req0 = 1'b1; a0 = 100; b0 = 1; cyc = 0;
    serve("t5", 2'b01, 11, 1'b1, we_n, sub_n);
    chk("t5_err", err, 1);
    chk("t5_quot", quot, 8);
    chk("t5_rem", rem, 92);
    @(negedge CLK);

    // reset in SUB clears everything, pointer included
    req0 = 1'b1; a0 = 1000; b0 = 3; cyc = 0;
    repeat (4) @(negedge CLK);
    chk("t6_in_sub", dp_s, 1);
    reset = 1'b1; req0 = 1'b0;
    @(negedge CLK);
    chk_reset_vals("t6_rst");
    reset = 1'b0;
    @(negedge CLK);
    chk("t6_no_done", done, 0);
    req0 = 1'b1; a0 = 6; b0 = 2;
    req1 = 1'b1; a1 = 5; b1 = 5;
    cyc = 0;
    serve("t6", 2'b01, 6, 1'b0, we_n, sub_n);
    chk("t6_quot", quot, 3);
    chk("t6_rem", rem, 0);
    chk("t6_err", err, 0);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_share_sched.md
# div_share_sched

Round-robin scheduler that shares one repeated-subtraction divide datapath (temp register, subtractor, `temp < divisor` comparator) between two requesters. It arbitrates requests, latches the winner's operands, and sequences the datapath through load and subtract phases. It counts subtractions to form the quotient, captures the remainder, and returns both with a one-cycle done pulse. It sits between the two client blocks and the shared datapath, and also handles divide-by-zero and iteration timeout.

## Interface
- WIDTH, 32, operand/result width.
- MAX_ITER, 65535, subtraction limit per operation; reaching it aborts with err. Counter width is $clog2(MAX_ITER+1).
- CLK  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- req0, req1  in  1 each  request from client 0/1; held with operands until matching done.
- a0, b0, a1, b1  in  WIDTH each  dividend/divisor of client 0/1, unsigned.
- gnt  out  2  one-hot grant, held from LOAD through DONE.
- done  out  2  one-cycle pulse to the served client.
- busy  out  1  high in every state except IDLE.
- err  out  1  valid with done: divide-by-zero or timeout.
- quot, rem  out  WIDTH each  result registers, held until next done.
- dp_a, dp_b  out  WIDTH each  latched dividend/divisor to datapath.
- dp_s  out  1  datapath mux select: 0 = load dp_a, 1 = temp − dp_b.
- dp_we  out  1  datapath temp register write enable.
- dp_x  in  1  datapath comparator: temp < dp_b (combinational).
- dp_temp  in  WIDTH  datapath temp register value.

## Operation
- States: IDLE, LOAD, SUB, DONE. State register is 2 bits.
- Reset: state=IDLE, priority pointer=0 (client 0 favoured), gnt=0, done=0, busy=0, err=0, quot=0, rem=0, count=0, operand latches=0, dp_s=0, dp_we=0.
- IDLE:
  - If any req is high, grant the client the pointer favours when both are high, otherwise the sole requester.
  - Latch that client's a/b into the operand registers and clear count.
  - Toggle the pointer to the other client after every grant.
  - If the latched b=0: go to DONE with err=1, quot=all ones, rem=a. The datapath is not touched.
  - Otherwise go to LOAD.
- LOAD: dp_s=0, dp_we=1 (temp←dp_a). Go to SUB.
- SUB: dp_s=1.
  - If dp_x=1: dp_we=0; capture quot=count (zero-extended), rem=dp_temp, err=0; go to DONE.
  - Else if count==MAX_ITER: dp_we=0; capture quot=count, rem=dp_temp, err=1; go to DONE.
  - Else: dp_we=1, count+1, stay in SUB.
- DONE: pulse done[granted]=1 for exactly one cycle, then go to IDLE.
  - gnt drops on the DONE→IDLE edge.
  - quot, rem and err hold until the next DONE.
- dp_s and dp_we are 0 in IDLE and DONE.
- A req that drops mid-operation does not abort it; the operation completes and done is still pulsed.
- A req still high in the IDLE cycle after done is treated as a new request.
- Operand inputs are ignored except in the IDLE grant cycle.
- Only one operation is in flight; the non-granted client waits, with no starvation thanks to the pointer toggle.

## Timing
- Cycle 0 = the IDLE cycle in which the grant is made.
- Normal operation with quotient q: LOAD in cycle 1, SUB in cycles 2..q+2, DONE (done pulse) in cycle q+3.
- Divide-by-zero: done in cycle 1.
- Timeout: done in cycle MAX_ITER+3.
- Back-to-back service: the second client is granted in the IDLE cycle following DONE, i.e. one idle cycle between consecutive done pulses.
- dp_we in SUB is combinational on dp_x and count; all other outputs are registered or decoded from state.
- reset mid-operation (any state): next cycle fully at reset values, including the pointer. The interrupted client gets no done and must re-request.

## Test plan
- req0, a0=17, b0=5 after reset → gnt=01 in cycles 1–6, done=01 in cycle 6, quot=3, rem=2, err=0.
- req0 and req1 together, a0=10 b0=3, a1=9 b1=9 → client 0 first: done0 in cycle 6, quot=3, rem=1. Client 1 granted in cycle 7: done1 in cycle 11, quot=1, rem=0.
- req1, a1=4, b1=7 → done1 in cycle 3, quot=0, rem=4, err=0, and only one SUB cycle.
- req0, a0=55, b0=0 → done0 in cycle 1, err=1, quot=FFFFFFFF, rem=55, and dp_we never asserted.
- MAX_ITER=8, req0, a0=100, b0=1 → done0 in cycle 11, err=1, quot=8, rem=92.
- reset asserted during SUB of a0=1000 b0=3 → outputs at reset values next cycle. A subsequent req0 with a0=6, b0=2 → done0 in cycle 6, quot=3, rem=0, with the pointer back at client 0.
